// File: rtl/rbcp_pkg.sv
// Shared definitions for the SiTCP RBCP local-bus responder.
//   - bus widths (address / data) and the largest supported ack latency
//   - responder state encoding
package rbcp_pkg;

  localparam int RBCP_ADDR_W      = 32;
  localparam int RBCP_DATA_W      = 8;
  localparam int RBCP_MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rbcp_state_e;

endpackage

// File: rtl/rbcp_reg_responder_if.sv
// RBCP local-bus signal bundle.
//   master : SiTCP side, drives LOC_ACT/LOC_ADDR/LOC_WD/LOC_WE/LOC_RE,
//            receives LOC_ACK/LOC_RD
//   slave  : responder side, the mirror image
interface rbcp_reg_responder_if;
  import rbcp_pkg::*;

  logic                   LOC_ACT;
  logic [RBCP_ADDR_W-1:0] LOC_ADDR;
  logic [RBCP_DATA_W-1:0] LOC_WD;
  logic                   LOC_WE;
  logic                   LOC_RE;
  logic                   LOC_ACK;
  logic [RBCP_DATA_W-1:0] LOC_RD;

  modport master (
    output LOC_ACT, LOC_ADDR, LOC_WD, LOC_WE, LOC_RE,
    input  LOC_ACK, LOC_RD
  );

  modport slave (
    input  LOC_ACT, LOC_ADDR, LOC_WD, LOC_WE, LOC_RE,
    output LOC_ACK, LOC_RD
  );

endinterface

// File: rtl/rbcp_reg_responder.sv
// Byte-wide register-file responder on the SiTCP RBCP local bus.
// Decodes a window of N_RW read/write bytes followed by N_RO read-only
// status bytes starting at BASE_ADDR, and answers each accepted strobe with
// a one-cycle LOC_ACK exactly ACK_LATENCY cycles after the strobe.
// Ports:
//   CLK, RSTn  : clock, synchronous active-low reset
//   bus        : RBCP local bus (slave side)
//   REG_OUT    : RW register contents, byte k at [8k+7:8k]
//   WR_STROBE  : one-cycle pulse on bit k when RW register k is written
//   STATUS_IN  : read-only bytes, byte j appears at offset N_RW+j
module rbcp_reg_responder
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                     N_RW        = 16,
  parameter int                     N_RO        = 4,
  parameter int                     ACK_LATENCY = 1,
  parameter logic [RBCP_DATA_W-1:0] RW_INIT     = 8'h00,
  // STATUS_IN keeps at least one byte so N_RO=0 still yields a legal port
  localparam int                    RO_SLOTS    = (N_RO > 0) ? N_RO : 1
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  rbcp_reg_responder_if.slave       bus,
  output logic [8*N_RW-1:0]         REG_OUT,
  output logic [N_RW-1:0]           WR_STROBE,
  input  logic [8*RO_SLOTS-1:0]     STATUS_IN
);

  localparam logic [RBCP_ADDR_W-1:0] WIN_SIZE = RBCP_ADDR_W'(N_RW + N_RO);
  localparam logic [RBCP_ADDR_W-1:0] RW_SIZE  = RBCP_ADDR_W'(N_RW);
  // WAIT lasts ACK_LATENCY-1 cycles; the counter starts at 0, so the last
  // WAIT cycle is the one where it reads ACK_LATENCY-2.
  localparam logic [1:0] WAIT_LAST =
    (ACK_LATENCY > 1) ? 2'(ACK_LATENCY - 2) : 2'd0;

  logic [RBCP_ADDR_W-1:0] offset_s;
  logic                   hit_s;
  logic                   is_rw_s;
  logic                   qual_s;
  rbcp_state_e            state_r;
  rbcp_state_e            state_s;
  logic [1:0]             cnt_r;
  logic [1:0]             cnt_s;
  logic                   ack_r;
  logic [RBCP_DATA_W-1:0] rd_r;
  logic [RBCP_DATA_W-1:0] rd_sel_s;
  logic [RBCP_DATA_W-1:0] regs_r [N_RW];
  logic [N_RW-1:0]        wr_strobe_r;

  // Modulo-2^32 subtraction: addresses below BASE_ADDR wrap to a huge
  // offset and fall outside the window.
  assign offset_s = bus.LOC_ADDR - BASE_ADDR;
  assign hit_s    = (offset_s < WIN_SIZE);
  assign is_rw_s  = (offset_s < RW_SIZE);
  assign qual_s   = (bus.LOC_WE ^ bus.LOC_RE) && bus.LOC_ACT && hit_s &&
                    (state_r == IDLE);

  // Next-state and latency-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (qual_s) begin
          cnt_s   = 2'd0;
          state_s = (ACK_LATENCY == 1) ? ACK : WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // Losing LOC_ACT abandons the transaction without an ack.
        if (!bus.LOC_ACT) begin
          state_s = IDLE;
        end else if (cnt_r == WAIT_LAST) begin
          state_s = ACK;
        end else begin
          cnt_s = cnt_r + 2'd1;
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // State, counter and registered acknowledge.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= (state_s == ACK);
    end
  end

  // Read multiplexer over RW registers and status bytes.
  always_comb begin
    rd_sel_s = 8'h00;
    for (int k = 0; k < N_RW; k++) begin
      rd_sel_s = (offset_s == RBCP_ADDR_W'(k)) ? regs_r[k] : rd_sel_s;
    end
    for (int j = 0; j < N_RO; j++) begin
      rd_sel_s = (offset_s == RBCP_ADDR_W'(N_RW + j)) ?
                 STATUS_IN[8*j +: 8] : rd_sel_s;
    end
  end

  // Register file, write strobes and read holding register.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int k = 0; k < N_RW; k++) begin
        regs_r[k] <= RW_INIT;
      end
      wr_strobe_r <= {N_RW{1'b0}};
      rd_r        <= 8'h00;
    end else begin
      wr_strobe_r <= {N_RW{1'b0}};
      // Writes to RO offsets are acked by the FSM but touch nothing here.
      if (qual_s && bus.LOC_WE && is_rw_s) begin
        for (int k = 0; k < N_RW; k++) begin
          if (offset_s == RBCP_ADDR_W'(k)) begin
            regs_r[k]      <= bus.LOC_WD;
            wr_strobe_r[k] <= 1'b1;
          end
        end
      end
      if (qual_s && bus.LOC_RE) begin
        rd_r <= rd_sel_s;
      end
    end
  end

  for (genvar g = 0; g < N_RW; g++) begin : g_reg_out
    assign REG_OUT[8*g +: 8] = regs_r[g];
  end

  assign WR_STROBE   = wr_strobe_r;
  assign bus.LOC_ACK = ack_r;
  assign bus.LOC_RD  = rd_r;

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Self-checking bench: two responders (ack latency 1 and 3) share one
// stimulus stream. Expected acks are queued per responder when a strobe is
// driven and popped by a monitor when LOC_ACK is seen.
module tb_rbcp_reg_responder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  typedef struct {
    logic [7:0] rd;
    int         cyc;
  } exp_t;

  logic         clk;
  logic         rst1_n;
  logic         rst3_n;
  logic         act;
  logic [31:0]  addr;
  logic [7:0]   wd;
  logic         we;
  logic         re;
  logic [31:0]  status_v;
  logic [127:0] reg_out1;
  logic [127:0] reg_out3;
  logic [15:0]  wr_strobe1;
  logic [15:0]  wr_strobe3;

  logic [127:0] model1;
  logic [127:0] model3;
  logic [7:0]   last_rd1;
  logic [7:0]   last_rd3;
  exp_t         q1[$];
  exp_t         q3[$];
  int           ack_cnt1;
  int           ack_cnt3;
  int           cyc;
  int           n_tests;
  int           n_fail;

  rbcp_reg_responder_if if1 ();
  rbcp_reg_responder_if if3 ();

  assign if1.LOC_ACT  = act;
  assign if1.LOC_ADDR = addr;
  assign if1.LOC_WD   = wd;
  assign if1.LOC_WE   = we;
  assign if1.LOC_RE   = re;
  assign if3.LOC_ACT  = act;
  assign if3.LOC_ADDR = addr;
  assign if3.LOC_WD   = wd;
  assign if3.LOC_WE   = we;
  assign if3.LOC_RE   = re;

  rbcp_reg_responder #(
    .BASE_ADDR(BASE), .N_RW(16), .N_RO(4), .ACK_LATENCY(1), .RW_INIT(8'h00)
  ) dut1 (
    .CLK(clk), .RSTn(rst1_n), .bus(if1),
    .REG_OUT(reg_out1), .WR_STROBE(wr_strobe1), .STATUS_IN(status_v)
  );

  rbcp_reg_responder #(
    .BASE_ADDR(BASE), .N_RW(16), .N_RO(4), .ACK_LATENCY(3), .RW_INIT(8'h00)
  ) dut3 (
    .CLK(clk), .RSTn(rst3_n), .bus(if3),
    .REG_OUT(reg_out3), .WR_STROBE(wr_strobe3), .STATUS_IN(status_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: each ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if1.LOC_ACK === 1'b1) begin
      exp_t e;
      ack_cnt1++;
      check("ack1_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("ack1_rd", if1.LOC_RD, e.rd);
        check("ack1_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (if3.LOC_ACK === 1'b1) begin
      exp_t e;
      ack_cnt3++;
      check("ack3_expected", q3.size() > 0, 1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check("ack3_rd", if3.LOC_RD, e.rd);
        check("ack3_cycle", cyc, e.cyc);
      end
    end
  end

  // One strobe; act stays high for 'hold' extra cycles after the strobe cycle.
  task automatic access(input logic we_i, input logic re_i,
                        input logic [31:0] addr_i, input logic [7:0] wd_i,
                        input logic act_i, input int hold);
    logic [31:0] off;
    logic        q;
    int          c;
    int          o;
    logic [15:0] ws;
    @(negedge clk);
    act = act_i; addr = addr_i; wd = wd_i; we = we_i; re = re_i;
    c   = cyc;
    off = addr_i - BASE;
    q   = act_i && (we_i ^ re_i) && (off < 32'd20);
    o   = int'(off[4:0]);
    ws  = 16'h0000;
    if (q && we_i && off < 32'd16) begin
      model1[o*8 +: 8] = wd_i;
      model3[o*8 +: 8] = wd_i;
      ws[o] = 1'b1;
    end
    if (q && re_i) begin
      if (off < 32'd16) begin
        last_rd1 = model1[o*8 +: 8];
        last_rd3 = model3[o*8 +: 8];
      end else begin
        last_rd1 = status_v[(o-16)*8 +: 8];
        last_rd3 = status_v[(o-16)*8 +: 8];
      end
    end
    if (q) q1.push_back('{rd: last_rd1, cyc: c + 1});
    if (q && hold >= 2) q3.push_back('{rd: last_rd3, cyc: c + 3});
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    if (hold == 0) act = 1'b0;
    check("wr_strobe1", wr_strobe1, ws);
    check("wr_strobe3", wr_strobe3, ws);
    check("reg_out1", reg_out1, model1);
    check("reg_out3", reg_out3, model3);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      act = 1'b0;
    end
    @(negedge clk);
    check("wr_strobe1_clear", wr_strobe1, 16'h0000);
    check("wr_strobe3_clear", wr_strobe3, 16'h0000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a1;
    int a3;
    int c;
    cyc = 0; n_tests = 0; n_fail = 0; ack_cnt1 = 0; ack_cnt3 = 0;
    act = 1'b0; addr = 32'h0; wd = 8'h00; we = 1'b0; re = 1'b0;
    status_v = 32'hDEAD_BEEF;
    model1 = 128'h0; model3 = 128'h0; last_rd1 = 8'h00; last_rd3 = 8'h00;
    rst1_n = 1'b0; rst3_n = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_ack1", if1.LOC_ACK, 0);
    check("rst_ack3", if3.LOC_ACK, 0);
    check("rst_rd1", if1.LOC_RD, 8'h00);
    check("rst_rd3", if3.LOC_RD, 8'h00);
    check("rst_reg1", reg_out1, 128'h0);
    check("rst_reg3", reg_out3, 128'h0);
    check("rst_ws1", wr_strobe1, 16'h0000);
    check("rst_ws3", wr_strobe3, 16'h0000);
    rst1_n = 1'b1; rst3_n = 1'b1;
    repeat (2) @(negedge clk);

    // Writes, read-backs, status reads, RO write
    access(1'b1, 1'b0, 32'h0000_0103, 8'hA5, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0103, 8'h00, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0111, 8'h00, 1'b1, 4);
    access(1'b1, 1'b0, 32'h0000_0111, 8'h77, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0110, 8'h00, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0113, 8'h00, 1'b1, 4);
    access(1'b1, 1'b0, 32'h0000_010F, 8'hFF, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_010F, 8'h00, 1'b1, 4);
    access(1'b1, 1'b0, 32'h0000_0100, 8'h3C, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0100, 8'h00, 1'b1, 4);

    // Misses, double strobe, inactive bus: none may be acked
    a1 = ack_cnt1; a3 = ack_cnt3;
    access(1'b1, 1'b0, 32'h0000_00FF, 8'h11, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0114, 8'h00, 1'b1, 4);
    access(1'b1, 1'b0, 32'hFFFF_FFFF, 8'h22, 1'b1, 4);
    access(1'b0, 1'b1, 32'hFFFF_FFFF, 8'h00, 1'b1, 4);
    access(1'b1, 1'b1, 32'h0000_0104, 8'h33, 1'b1, 4);
    access(1'b1, 1'b0, 32'h0000_0105, 8'h44, 1'b0, 4);
    repeat (16) @(negedge clk);
    check("ignored_no_ack1", ack_cnt1 - a1, 0);
    check("ignored_no_ack3", ack_cnt3 - a3, 0);

    // Abort: LOC_ACT drops one cycle after the strobe
    a3 = ack_cnt3;
    access(1'b0, 1'b1, 32'h0000_0103, 8'h00, 1'b1, 0);
    repeat (6) @(negedge clk);
    check("abort_no_ack3", ack_cnt3 - a3, 0);
    access(1'b0, 1'b1, 32'h0000_010F, 8'h00, 1'b1, 4);

    // Reset of the latency-3 responder the cycle after a write strobe
    a3 = ack_cnt3;
    @(negedge clk);
    act = 1'b1; addr = 32'h0000_0102; wd = 8'h5A; we = 1'b1;
    c = cyc;
    model1[2*8 +: 8] = 8'h5A;
    q1.push_back('{rd: last_rd1, cyc: c + 1});
    @(negedge clk);
    we = 1'b0; rst3_n = 1'b0;
    model3 = 128'h0; last_rd3 = 8'h00;
    repeat (3) @(negedge clk);
    rst3_n = 1'b1; act = 1'b0;
    repeat (6) @(negedge clk);
    check("rstmid_no_ack3", ack_cnt3 - a3, 0);
    check("rstmid_reg3", reg_out3, 128'h0);
    check("rstmid_rd3", if3.LOC_RD, 8'h00);
    check("rstmid_reg1", reg_out1, model1);
    access(1'b0, 1'b1, 32'h0000_0100, 8'h00, 1'b1, 4);
    access(1'b0, 1'b1, 32'h0000_0102, 8'h00, 1'b1, 4);

    repeat (8) @(negedge clk);
    check("pending1", q1.size(), 0);
    check("pending3", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
